ping_pong_ctrl: RTL and testbench
=================================

# ping_pong_ctrl

Bank-swap sequencer for `dual_port_ping_pong_ram`. It tracks the fill state of the write-side and read-side banks and exposes ready/valid handshakes to one producer and one consumer. It issues the single-cycle `switch` pulse only after the RAM's registered write pipeline has settled, and hands the filled word count to the consumer. It sits between the layer-level scheduler's producer/consumer engines and the RAM's `switch` input.

## Interface
- `DEPTH`, 256: words per bank; must match the RAM instance.
- `ADDR_W`, `bw(DEPTH)`: derived; do not override.
- `SETTLE_CYC`, 2: cycles spent in SETTLE before the swap; legal range 1..15.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `fill_ready`  out  1  producer may write the current write bank.
- `fill_done`  in  1  pulse: producer finished the write bank.
- `fill_cnt`  in  ADDR_W+1  words written; sampled with `fill_done`.
- `drain_valid`  out  1  read bank holds data; consumer may read.
- `drain_len`  out  ADDR_W+1  word count of the read bank.
- `drain_done`  in  1  pulse: consumer finished the read bank.
- `switch`  out  1  one-cycle pulse; drives the RAM `switch`.
- `bank_sel`  out  1  mirror of the RAM's internal bank flag.
- `swap_cnt`  out  32  completed swaps (see Configuration).
- `stall_cnt`  out  32  producer stall cycles (see Configuration).

## Operation
- FSM states: FILL, WAIT, SETTLE, SWITCH. Reset state is FILL.
- Flag `rd_full` marks that the read bank holds valid data. It resets to 0.
- FILL:
  - `fill_ready`=1.
  - `fill_done` with `fill_cnt`>0 → WAIT, and `len_r` latches min(`fill_cnt`, DEPTH).
  - `fill_done` with `fill_cnt`=0 is ignored; the FSM stays in FILL.
- WAIT:
  - If `!rd_full || drain_done` → SETTLE, and the settle counter loads 0.
  - Otherwise stay in WAIT (producer stall).
- SETTLE: the counter increments each cycle. When it reaches SETTLE_CYC-1 → SWITCH.
- SWITCH:
  - `switch`=1 for exactly this cycle.
  - Next state FILL. `rd_full`<=1, `drain_len`<=`len_r`, `bank_sel`<=~`bank_sel`.
- `drain_done` while `rd_full`=1 (any state) clears `rd_full`. `drain_done` while `rd_full`=0 is ignored.
- `drain_valid` = `rd_full` (registered). `fill_ready` is decoded from state FILL.
- `switch` is decoded from state SWITCH, so it is glitch-free and tied to the registered state.
- `bank_sel` has no reset and is initialized to 0 at configuration, matching the RAM flag.
  - It toggles only on `switch`, so a mid-operation reset keeps it aligned with the RAM.
- Reset mid-operation: state→FILL, `rd_full`→0, `drain_len`→0, counters→0. Bank contents are discarded logically.
- Reset values: `fill_ready`=1, `drain_valid`=0, `drain_len`=0, `switch`=0, `swap_cnt`=0, `stall_cnt`=0. `bank_sel` is unchanged by reset.

## Timing
- The producer's last write may coincide with `fill_done` (cycle t).
- Swap latency with the read bank free at t:
  - WAIT at t+1.
  - SETTLE from t+2 to t+1+SETTLE_CYC.
  - `switch` at t+2+SETTLE_CYC.
  - `drain_valid`=1 and `fill_ready`=1 at t+3+SETTLE_CYC. With the default this is `switch` at t+4 and valid at t+5.
- SETTLE_CYC≥1 guarantees the RAM's one-cycle registered write lands before its flag toggles.
- The producer must not write while `fill_ready`=0. The consumer must not issue `rd_en` after `drain_done`.
- The consumer asserts `drain_done` only after its last read data returns; RAM read latency is 2 cycles.
- `drain_done` and `fill_done` in the same cycle in FILL:
  - `rd_full` clears and the FSM enters WAIT.
  - The next cycle sees `rd_full`=0 and goes to SETTLE.
- `drain_done` in WAIT: SETTLE is entered the next cycle, with no extra idle cycle.

## Configuration
- `PP_CTRL_STATS_EN` defined:
  - `swap_cnt` increments in every SWITCH cycle.
  - `stall_cnt` increments each WAIT cycle with `rd_full`=1 and `drain_done`=0.
  - Both are 32-bit, wrap, and reset to 0.
- `PP_CTRL_STATS_EN` undefined: both ports are tied to 0 and no counter logic is synthesized. The port list is identical in both builds.

## Test plan
- Reset, then `fill_done` with `fill_cnt`=100 at t=10 → `switch` only at t=14, `drain_valid`=1 and `drain_len`=100 at t=15, `bank_sel` 0→1.
- Read bank still full, second `fill_done` (cnt=50) → FSM held in WAIT, `fill_ready`=0. `drain_done` at cycle d → `switch` at d+3, `drain_len`=50. With stats enabled, `stall_cnt` equals the WAIT cycles.
- `fill_done` with `fill_cnt`=0 → no `switch`, FSM remains in FILL. `fill_cnt`=300 with DEPTH=256 → `drain_len`=256.
- `fill_done` and `drain_done` in the same cycle with `rd_full`=1 → exactly one `switch`, 4 cycles later.
- `rst` asserted during SETTLE → no `switch`, `drain_valid`=0, `bank_sel` unchanged. After release, a full fill/swap cycle toggles `bank_sel` once. Scoreboard the RAM data to confirm bank alignment.
- 1000 random fill/drain pulses with a RAM model → every word written is read back exactly once in order. `swap_cnt` equals the number of swaps, or 0 with the macro undefined.

Source files
------------

// File: rtl/ping_pong_ctrl.sv
// rtl/ping_pong_ctrl.sv - bank-swap sequencer for dual_port_ping_pong_ram
// Optional swap/stall statistics are built only when PP_CTRL_STATS_EN is defined.
module ping_pong_ctrl #(
   parameter int DEPTH      = 256,
   parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int SETTLE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              fill_ready,
   input  logic              fill_done,
   input  logic [ADDR_W:0]   fill_cnt,
   output logic              drain_valid,
   output logic [ADDR_W:0]   drain_len,
   input  logic              drain_done,
   output logic              switch,
   output logic              bank_sel,
   output logic [31:0]       swap_cnt,
   output logic [31:0]       stall_cnt
);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_WAIT   = 2'd1,
      S_SETTLE = 2'd2,
      S_SWITCH = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t            state, state_nxt;
   logic [3:0]        settle_cnt, settle_cnt_nxt;
   logic [ADDR_W:0]   len_r, len_nxt;
   logic [ADDR_W:0]   drain_len_r;
   logic              rd_full;
   // No reset: this flag must track the RAM's own bank flag, which only toggles on switch.
   logic              bank_sel_r = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FILL;
         settle_cnt <= '0;
         len_r      <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_cnt_nxt;
         len_r      <= len_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      settle_cnt_nxt = settle_cnt;
      len_nxt        = len_r;
      case (state)
         S_FILL: begin
            if (fill_done && (fill_cnt != '0)) begin
               state_nxt = S_WAIT;
               len_nxt   = (fill_cnt > DEPTH_W) ? DEPTH_W : fill_cnt;
            end
         end
         S_WAIT: begin
            if (!rd_full || drain_done) begin
               state_nxt      = S_SETTLE;
               settle_cnt_nxt = '0;
            end
         end
         S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt = S_SWITCH;
            end else begin
               settle_cnt_nxt = settle_cnt + 4'd1;
            end
         end
         S_SWITCH: begin
            state_nxt = S_FILL;
         end
         default: begin
            state_nxt = S_FILL;
         end
      endcase
   end

   // SWITCH can never coincide with a live drain_done: rd_full is already clear by then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_full     <= 1'b0;
         drain_len_r <= '0;
      end else if (state == S_SWITCH) begin
         rd_full     <= 1'b1;
         drain_len_r <= len_r;
      end else if (drain_done) begin
         rd_full     <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_SWITCH) begin
         bank_sel_r <= ~bank_sel_r;
      end
   end

   assign fill_ready  = (state == S_FILL);
   assign switch      = (state == S_SWITCH);
   assign drain_valid = rd_full;
   assign drain_len   = drain_len_r;
   assign bank_sel    = bank_sel_r;

`ifdef PP_CTRL_STATS_EN
   logic [31:0] swap_cnt_r;
   logic [31:0] stall_cnt_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         swap_cnt_r  <= '0;
         stall_cnt_r <= '0;
      end else begin
         if (state == S_SWITCH) begin
            swap_cnt_r <= swap_cnt_r + 32'd1;
         end
         if ((state == S_WAIT) && rd_full && !drain_done) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
      end
   end

   assign swap_cnt  = swap_cnt_r;
   assign stall_cnt = stall_cnt_r;
`else
   assign swap_cnt  = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// tb/tb_ping_pong_ctrl.sv - self-checking bench for ping_pong_ctrl
// Directed vector table, reset-in-SETTLE sequence, randomized traffic against a RAM/queue model.
module tb_ping_pong_ctrl;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   localparam int SETTLE = 2;
   localparam int NF     = 400;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              fill_ready;
   logic              fill_done = 1'b0;
   logic [ADDR_W:0]   fill_cnt = '0;
   logic              drain_valid;
   logic [ADDR_W:0]   drain_len;
   logic              drain_done = 1'b0;
   logic              switch;
   logic              bank_sel;
   logic [31:0]       swap_cnt;
   logic [31:0]       stall_cnt;

   ping_pong_ctrl #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE)) dut (
      .clk(clk), .rst(rst),
      .fill_ready(fill_ready), .fill_done(fill_done), .fill_cnt(fill_cnt),
      .drain_valid(drain_valid), .drain_len(drain_len), .drain_done(drain_done),
      .switch(switch), .bank_sel(bank_sel),
      .swap_cnt(swap_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic            fd;
      logic [ADDR_W:0] cnt;
      logic            dd;
      logic            r;
      logic            v;
      logic            s;
      logic            b;
      logic [ADDR_W:0] len;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int fd, input int cnt, input int dd,
                      input int r, input int v, input int s, input int b, input int len);
      vec_t e;
      e.fd  = (fd != 0);
      e.cnt = (ADDR_W + 1)'(cnt);
      e.dd  = (dd != 0);
      e.r   = (r != 0);
      e.v   = (v != 0);
      e.s   = (s != 0);
      e.b   = (b != 0);
      e.len = (ADDR_W + 1)'(len);
      tbl.push_back(e);
   endtask

   // RAM model: writes land one cycle after issue, reads return two cycles after rd_en.
   logic [31:0]       mem [0:1][0:DEPTH-1];
   logic              ram_flag = 1'b0;
   logic              we = 1'b0, re = 1'b0;
   logic [ADDR_W-1:0] waddr = '0, raddr = '0;
   logic [31:0]       wdata = '0;
   logic              wv1 = 1'b0, rv1 = 1'b0, rv2 = 1'b0;
   logic [ADDR_W-1:0] wa1 = '0, ra1 = '0;
   logic [31:0]       wd1 = '0, rd2 = '0;
   int                sw_count = 0;

   always @(posedge clk) begin
      wv1 <= we;
      wa1 <= waddr;
      wd1 <= wdata;
      if (wv1) mem[int'(ram_flag)][wa1] <= wd1;
      rv1 <= re;
      ra1 <= raddr;
      rv2 <= rv1;
      rd2 <= mem[int'(~ram_flag)][ra1];
      if (switch === 1'b1) begin
         ram_flag <= ~ram_flag;
         sw_count <= sw_count + 1;
      end
   end

   int exp_q[$];
   int next_val = 1;
   int fills = 0, reads = 0, cyc = 0, sw_base = 0;
   int p_active = 0, p_len = 0, p_addr = 0;
   int c_active = 0, c_len = 0, c_addr = 0, c_ret = 0;
   logic [31:0] exp_swaps, exp_stalls;

   initial begin
      // stimulus table: inputs applied in cycle i, outputs expected in cycle i
      add(1,100,0, 1,0,0,0,0);
      add(0,0,0,   0,0,0,0,0);
      add(0,0,0,   0,0,0,0,0);
      add(0,0,0,   0,0,0,0,0);
      add(0,0,0,   0,0,1,0,0);
      add(1,50,0,  1,1,0,1,100);
      add(0,0,0,   0,1,0,1,100);
      add(0,0,0,   0,1,0,1,100);
      add(0,0,1,   0,1,0,1,100);
      add(0,0,0,   0,0,0,1,100);
      add(0,0,0,   0,0,0,1,100);
      add(0,0,0,   0,0,1,1,100);
      add(1,0,0,   1,1,0,0,50);
      add(1,300,1, 1,1,0,0,50);
      add(0,0,0,   0,0,0,0,50);
      add(0,0,0,   0,0,0,0,50);
      add(0,0,0,   0,0,0,0,50);
      add(0,0,0,   0,0,1,0,50);
      add(0,0,1,   1,1,0,1,256);
      add(0,0,1,   1,0,0,1,256);
      add(0,0,0,   1,0,0,1,256);

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(fill_ready), 1);
      chk("rst_valid", 32'(drain_valid), 0);
      chk("rst_switch", 32'(switch), 0);
      chk("rst_len", 32'(drain_len), 0);
      chk("rst_swap", swap_cnt, 0);
      chk("rst_stall", stall_cnt, 0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), 32'(fill_ready), 32'(tbl[i].r));
         chk($sformatf("v%0d_valid", i), 32'(drain_valid), 32'(tbl[i].v));
         chk($sformatf("v%0d_switch", i), 32'(switch), 32'(tbl[i].s));
         chk($sformatf("v%0d_bank", i), 32'(bank_sel), 32'(tbl[i].b));
         chk($sformatf("v%0d_len", i), 32'(drain_len), 32'(tbl[i].len));
         fill_done  = tbl[i].fd;
         fill_cnt   = tbl[i].cnt;
         drain_done = tbl[i].dd;
      end
`ifdef PP_CTRL_STATS_EN
      exp_swaps = 3; exp_stalls = 2;
`else
      exp_swaps = 0; exp_stalls = 0;
`endif
      chk("tbl_swap_cnt", swap_cnt, exp_swaps);
      chk("tbl_stall_cnt", stall_cnt, exp_stalls);
      chk("tbl_switches", sw_count, 3);

      // reset asserted during SETTLE
      @(negedge clk); fill_done = 1'b1; fill_cnt = 9'd10; drain_done = 1'b0;
      @(negedge clk); fill_done = 1'b0;
      @(negedge clk);
      chk("pre_rst_ready", 32'(fill_ready), 0);
      chk("pre_rst_switch", 32'(switch), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(fill_ready), 1);
      chk("mid_rst_valid", 32'(drain_valid), 0);
      chk("mid_rst_len", 32'(drain_len), 0);
      chk("mid_rst_bank", 32'(bank_sel), 1);
      chk("mid_rst_swap", swap_cnt, 0);
      chk("mid_rst_stall", stall_cnt, 0);
      rst = 1'b0;
      sw_base = sw_count;
      repeat (6) @(negedge clk);
      chk("post_rst_noswitch", sw_count, sw_base);
      chk("post_rst_bank", 32'(bank_sel), 1);
      fill_done = 1'b1; fill_cnt = 9'd7;
      @(negedge clk); fill_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_switch_t4", 32'(switch), 1);
      @(negedge clk);
      chk("post_rst_valid", 32'(drain_valid), 1);
      chk("post_rst_len", 32'(drain_len), 7);
      chk("post_rst_bank_once", 32'(bank_sel), 0);
      chk("post_rst_one_switch", sw_count, sw_base + 1);
      drain_done = 1'b1;
      @(negedge clk); drain_done = 1'b0;
      chk("post_rst_cleared", 32'(drain_valid), 0);

      // randomized producer/consumer traffic; every written word must come back once, in order
      while (cyc < 60000) begin
         @(negedge clk);
         cyc++;
         fill_done = 1'b0; drain_done = 1'b0; we = 1'b0; re = 1'b0;
         if (rv2 === 1'b1) begin
            if (exp_q.size() == 0) chk("rd_unexpected", rd2, 0);
            else chk("rd_data", rd2, exp_q.pop_front());
            c_ret++;
            reads++;
         end
         if (c_active == 0 && drain_valid) begin
            c_active = 1; c_len = int'(drain_len); c_addr = 0; c_ret = 0;
            chk("bank_align", 32'(bank_sel), 32'(ram_flag));
         end
         if (c_active != 0) begin
            if (c_addr < c_len) begin
               if ($urandom_range(3) != 0) begin
                  re = 1'b1; raddr = ADDR_W'(c_addr); c_addr++;
               end
            end else if (c_ret == c_len && $urandom_range(2) == 0) begin
               drain_done = 1'b1; c_active = 0;
            end
         end else if (!drain_valid && $urandom_range(15) == 0) begin
            drain_done = 1'b1;
         end
         if (fill_ready) begin
            if (p_active == 0 && fills < NF && $urandom_range(2) == 0) begin
               p_active = 1; p_len = $urandom_range(24, 1); p_addr = 0;
            end
            if (p_active != 0) begin
               if ($urandom_range(3) != 0) begin
                  we = 1'b1; waddr = ADDR_W'(p_addr); wdata = next_val;
                  exp_q.push_back(next_val);
                  next_val++; p_addr++;
                  if (p_addr == p_len) begin
                     fill_done = 1'b1; fill_cnt = (ADDR_W + 1)'(p_len);
                     p_active = 0; fills++;
                  end
               end
            end else if ($urandom_range(31) == 0) begin
               fill_done = 1'b1; fill_cnt = '0;
            end
         end
         if (fills >= NF && p_active == 0 && c_active == 0 && exp_q.size() == 0 && !drain_valid)
            break;
      end
      chk("rand_timeout", 32'(cyc >= 60000), 0);
      chk("rand_all_read", reads, next_val - 1);
      chk("rand_queue_empty", exp_q.size(), 0);
      chk("rand_switches", sw_count - sw_base, fills + 1);
`ifdef PP_CTRL_STATS_EN
      exp_swaps = 32'(sw_count - sw_base);
`else
      exp_swaps = 0;
`endif
      chk("rand_swap_cnt", swap_cnt, exp_swaps);
      chk("rand_bank_align", 32'(bank_sel), 32'(ram_flag));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
